noc_port_arbiter: RTL and testbench
===================================

# noc_port_arbiter

Shares one core-side NOC ip_port among up to NUM_REQ core execution units (PFCU, load/store, etc.), each of which would otherwise need its own port. TX requests are granted round-robin. The packet `id` field is rewritten with the requester index, and each reply is steered back by that index with the original `id` restored. The block sits between the execution units and the router-facing `ip_port`.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8); `id` field width ≥ $clog2(NUM_REQ)
- IDX_W, $clog2(NUM_REQ), requester index width (derived)

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  core clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- req_tx_submit  in  NUM_REQ  per-requester TX request, held until its tx_complete
- req_tx_packet  in  NUM_REQ×packet  per-requester outgoing packet
- req_tx_complete  out  NUM_REQ  one-hot, packet accepted by NOC this cycle
- req_rx_recieve  out  NUM_REQ  one-hot, reply waiting for this requester
- req_rx_packet  out  packet  reply with restored `id` (shared by all requesters)
- req_rx_complete  in  NUM_REQ  requester consumed its reply
- noc_tx_packet  out  packet  to ip_port dat_to_noc
- noc_tx_submit  out  1  to ip_port tx_submit
- noc_tx_complete  in  1  from ip_port tx_complete
- noc_prt_open  in  1  to_noc_prt_stat == port_open
- noc_rx_recieve  in  1  from ip_port rx_recieve
- noc_rx_packet  in  packet  from ip_port dat_from_noc
- noc_rx_complete  out  1  to ip_port rx_complete

## Operation
- TX FSM states:
  - TX_IDLE: eligible = req_tx_submit & ~outstanding. If eligible ≠ 0, pick the first set bit at or after rr_ptr (wrapping), latch grant index g and the packet, then go to TX_GRANT.
  - TX_GRANT: noc_tx_submit=1; noc_tx_packet = latched packet with id[IDX_W-1:0]=g and upper id bits 0.
  - TX_GRANT exit: when noc_prt_open && noc_tx_complete, req_tx_complete[g]=1 (combinational, same cycle). At that edge: outstanding[g]←1, saved_id[g]←original id, rr_ptr←(g+1) mod NUM_REQ, state→TX_IDLE.
- One outstanding transaction per requester. A requester with outstanding set is masked from arbitration until its reply is delivered.
- RX path (combinational steer):
  - Decode k = noc_rx_packet.id[IDX_W-1:0].
  - If noc_rx_recieve && k < NUM_REQ && outstanding[k]: req_rx_recieve[k]=1; req_rx_packet = noc_rx_packet with id=saved_id[k]; noc_rx_complete = req_rx_complete[k]. On the edge where that is 1, outstanding[k]←0.
  - Otherwise, if noc_rx_recieve (stray/invalid reply): noc_rx_complete=1 for that cycle, so the packet is dropped and never forwarded.
- TX and RX are independent. A grant and a reply delivery may complete on the same edge.

## Timing
- Reset (rst=0, async): state TX_IDLE, rr_ptr=0, outstanding=0, saved_id=0. All outputs 0; req_rx_packet and noc_tx_packet are 0.
- Reset mid-grant drops noc_tx_submit immediately. Any reply arriving after reset is handled as stray.
- Submit-to-noc_tx_submit latency: 1 cycle (submit seen in TX_IDLE at edge N, submit asserted in cycle N+1).
- noc_tx_packet is stable for the whole of TX_GRANT. Later changes to req_tx_packet are ignored.
- Minimum spacing between back-to-back grants: 2 cycles (GRANT, IDLE, GRANT).
- Reply delivered and the same requester re-submitting on one edge: the new request becomes eligible the cycle after outstanding clears.
- noc_tx_complete without noc_prt_open: ignored, and the FSM stays in TX_GRANT.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Configuration
- NOC_ARB_STATS_EN defined: adds outputs stat_grants (32 bit, +1 per completed grant) and stat_drops (16 bit, +1 per stray reply, saturating). Both reset to 0.
- NOC_ARB_STATS_EN undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- `packet`, `packet_type` and `port_stat` stay in structs.svh.
- Add `arb_tx_state` enum (TX_IDLE, TX_GRANT) to structs.svh.
- Sub-module `rr_pick`: combinational, takes NUM_REQ request vector plus rr_ptr and returns one-hot grant plus valid.

## Test plan
- Single requester 1 submits memory_read_request with id=5 → noc_tx_submit next cycle with id=1. Reply with id=1 → req_rx_recieve[1]=1, req_rx_packet.id=5. req_rx_complete[1] → noc_rx_complete=1 and outstanding[1] clears.
- Requesters 0, 1 and 3 submit simultaneously from reset → grants in order 0, 1, 3, each 2 cycles apart, with exactly one req_tx_complete pulse each.
- Requester 2 re-submits before its reply arrives → it is not granted again until after the reply is delivered. Requester 0 is granted in the meantime.
- Reply with id=3 while outstanding[3]=0 → noc_rx_complete=1 for one cycle, no req_rx_recieve, stat_drops=1 (with NOC_ARB_STATS_EN).
- noc_prt_open=0 for 5 cycles during TX_GRANT with tx_complete high → no completion and submit held. Port opens → completion in that cycle.
- rst asserted low mid-TX_GRANT → noc_tx_submit falls without a clock edge. After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/noc_port_arbiter_pkg.sv
// Shared types for the NOC port arbiter: packet payload, packet kinds,
// port status and the TX arbitration state encoding.
package noc_port_arbiter_pkg;

    localparam int unsigned ID_W   = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        memory_read_request  = 3'd0,
        memory_read_reply    = 3'd1,
        memory_write_request = 3'd2,
        memory_write_reply   = 3'd3,
        pfcu_request         = 3'd4,
        pfcu_reply           = 3'd5
    } packet_type;

    typedef enum logic [1:0] {
        port_closed = 2'd0,
        port_open   = 2'd1,
        port_busy   = 2'd2
    } port_stat;

    typedef struct packed {
        packet_type          ptype;
        logic [ID_W-1:0]     id;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } packet;

    typedef logic [0:0] arb_tx_state;
    localparam arb_tx_state TX_IDLE  = 1'b0;
    localparam arb_tx_state TX_GRANT = 1'b1;

endpackage

// File: rtl/noc_port_arbiter_rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr (wrapping).
//   req   - request vector
//   ptr   - starting index for the search
//   grant - one-hot selected request
//   valid - at least one request was set
module noc_port_arbiter_rr_pick
    import noc_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    // Walk the requests starting at ptr; the first hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Shares one core-side NOC ip_port among NUM_REQ execution units.
// TX requests are granted round-robin; the packet id is replaced by the
// requester index and the original id is restored on the matching reply.
// Replies that do not match an outstanding requester are dropped.
//
// Ports:
//   clk, rst            - core clock, asynchronous active-low reset
//   req_tx_*            - per-requester submit / packet / completion
//   req_rx_*            - per-requester reply steering and consume handshake
//   noc_tx_*, noc_prt_open, noc_rx_* - router-facing ip_port
//   stat_grants, stat_drops - only when NOC_ARB_STATS_EN is defined
module noc_port_arbiter
    import noc_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_tx_submit,
    input  packet              req_tx_packet [NUM_REQ],
    output logic [NUM_REQ-1:0] req_tx_complete,
    output logic [NUM_REQ-1:0] req_rx_recieve,
    output packet              req_rx_packet,
    input  logic [NUM_REQ-1:0] req_rx_complete,
    output packet              noc_tx_packet,
    output logic               noc_tx_submit,
    input  logic               noc_tx_complete,
    input  logic               noc_prt_open,
    input  logic               noc_rx_recieve,
    input  packet              noc_rx_packet,
    output logic               noc_rx_complete
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [31:0]        stat_grants,
    output logic [15:0]        stat_drops
`endif
);

    localparam int unsigned    NUM_PAD   = 1 << IDX_W;
    localparam logic [IDX_W:0] NUM_REQ_L = (IDX_W+1)'(NUM_REQ);

    arb_tx_state        state, state_next;
    logic [IDX_W-1:0]   grant_idx, rr_ptr, pick_idx, rx_k;
    logic [ID_W-1:0]    orig_id;
    logic [ID_W-1:0]    saved_id [NUM_PAD];
    packet              tx_pkt, tx_pkt_next;
    logic [NUM_REQ-1:0] outstanding, out_next, eligible, pick_onehot;
    logic [NUM_PAD-1:0] out_pad, rxc_pad;
    logic               pick_valid, start_grant, tx_fire;
    logic               rx_hit, rx_deliver, rx_stray;

    assign eligible = req_tx_submit & ~outstanding;

    noc_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (pick_onehot),
        .valid (pick_valid)
    );

    // Index of the picked requester and its packet with the id rewritten.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) pick_idx = IDX_W'(i);
        end
        tx_pkt_next    = req_tx_packet[pick_idx];
        tx_pkt_next.id = ID_W'(pick_idx);
    end

    // TX state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= TX_IDLE;
        else      state <= state_next;
    end

    // TX next-state and handshake decode.
    always_comb begin
        state_next  = state;
        start_grant = 1'b0;
        tx_fire     = 1'b0;
        case (state)
            TX_IDLE: begin
                if (pick_valid) begin
                    start_grant = 1'b1;
                    state_next  = TX_GRANT;
                end
            end
            TX_GRANT: begin
                if (noc_prt_open && noc_tx_complete) begin
                    tx_fire    = 1'b1;
                    state_next = TX_IDLE;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    assign noc_tx_submit = (state == TX_GRANT);
    assign noc_tx_packet = tx_pkt;

    // RX steering: the low id bits name the requester that owns the reply.
    always_comb begin
        rx_k       = noc_rx_packet.id[IDX_W-1:0];
        out_pad    = NUM_PAD'(outstanding);
        rxc_pad    = NUM_PAD'(req_rx_complete);
        rx_hit     = rst && noc_rx_recieve && ({1'b0, rx_k} < NUM_REQ_L) && out_pad[rx_k];
        rx_deliver = rx_hit && rxc_pad[rx_k];
        rx_stray   = rst && noc_rx_recieve && !rx_hit;

        noc_rx_complete = rx_deliver || rx_stray;
        req_rx_packet   = '0;
        if (rx_hit) begin
            req_rx_packet    = noc_rx_packet;
            req_rx_packet.id = saved_id[rx_k];
        end

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_rx_recieve[i]  = rx_hit && (rx_k == IDX_W'(i));
            req_tx_complete[i] = tx_fire && (grant_idx == IDX_W'(i));
            // A granted requester is never outstanding, so set and clear never collide.
            out_next[i] = (outstanding[i] && !(rx_deliver && (rx_k == IDX_W'(i))))
                        || (tx_fire && (grant_idx == IDX_W'(i)));
        end
    end

    // Grant latch, round-robin pointer and per-requester bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_idx   <= '0;
            rr_ptr      <= '0;
            orig_id     <= '0;
            tx_pkt      <= '0;
            outstanding <= '0;
            for (int unsigned i = 0; i < NUM_PAD; i++) saved_id[i] <= '0;
        end else begin
            if (start_grant) begin
                grant_idx <= pick_idx;
                orig_id   <= req_tx_packet[pick_idx].id;
                tx_pkt    <= tx_pkt_next;
            end
            if (tx_fire) begin
                saved_id[grant_idx] <= orig_id;
                rr_ptr <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
            end
            outstanding <= out_next;
        end
    end

`ifdef NOC_ARB_STATS_EN
    // Grant counter and saturating stray-reply counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants <= '0;
            stat_drops  <= '0;
        end else begin
            if (tx_fire) stat_grants <= stat_grants + 32'd1;
            if (rx_stray && (stat_drops != 16'hFFFF)) stat_drops <= stat_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Self-checking bench for noc_port_arbiter: reset checks, a vector table for
// the single-requester flow, hand sequences for multi-cycle corners, and a
// randomized run against a transaction-level reference model.
module tb_noc_port_arbiter;
    import noc_port_arbiter_pkg::*;

    localparam int N = 4;

    logic         clk, rst;
    logic [N-1:0] req_tx_submit, req_tx_complete, req_rx_recieve, req_rx_complete;
    packet        req_tx_packet [N];
    packet        req_rx_packet, noc_tx_packet, noc_rx_packet;
    logic         noc_tx_submit, noc_tx_complete, noc_prt_open, noc_rx_recieve, noc_rx_complete;
`ifdef NOC_ARB_STATS_EN
    logic [31:0]  stat_grants;
    logic [15:0]  stat_drops;
`endif

    noc_port_arbiter #(.NUM_REQ(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_tx_submit   (req_tx_submit),
        .req_tx_packet   (req_tx_packet),
        .req_tx_complete (req_tx_complete),
        .req_rx_recieve  (req_rx_recieve),
        .req_rx_packet   (req_rx_packet),
        .req_rx_complete (req_rx_complete),
        .noc_tx_packet   (noc_tx_packet),
        .noc_tx_submit   (noc_tx_submit),
        .noc_tx_complete (noc_tx_complete),
        .noc_prt_open    (noc_prt_open),
        .noc_rx_recieve  (noc_rx_recieve),
        .noc_rx_packet   (noc_rx_packet),
        .noc_rx_complete (noc_rx_complete)
`ifdef NOC_ARB_STATS_EN
        ,
        .stat_grants     (stat_grants),
        .stat_drops      (stat_drops)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_tx_submit   = '0;
        req_rx_complete = '0;
        noc_tx_complete = 1'b0;
        noc_prt_open    = 1'b0;
        noc_rx_recieve  = 1'b0;
        noc_rx_packet   = '0;
    endtask

    task automatic init_pkts();
        for (int i = 0; i < N; i++) begin
            req_tx_packet[i].ptype = memory_write_request;
            req_tx_packet[i].id    = 8'(8'h10 + i);
            req_tx_packet[i].addr  = 32'(32'h2000_0000 + i * 4);
            req_tx_packet[i].data  = 32'(32'hA5A5_0000 + i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    function automatic packet rand_pkt();
        packet p;
        p.ptype = packet_type'(3'($urandom_range(0, 5)));
        p.id    = 8'($urandom);
        p.addr  = $urandom;
        p.data  = $urandom;
        return p;
    endfunction

    function automatic int idx_of(input logic [N-1:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (oh[i]) r = i;
        return r;
    endfunction

    typedef struct {
        logic [N-1:0] sub;
        logic         open, cmpl, rxv;
        logic [7:0]   rx_id;
        logic [N-1:0] rxc;
        logic         e_txs;
        logic [7:0]   e_txid;
        logic [N-1:0] e_txc, e_rxr;
        logic [7:0]   e_rxid;
        logic         e_nrc;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] sub, input logic open, input logic cmpl,
                                input logic rxv, input logic [7:0] rx_id, input logic [N-1:0] rxc,
                                input logic e_txs, input logic [7:0] e_txid, input logic [N-1:0] e_txc,
                                input logic [N-1:0] e_rxr, input logic [7:0] e_rxid, input logic e_nrc);
        vec_t v;
        v.sub = sub; v.open = open; v.cmpl = cmpl; v.rxv = rxv; v.rx_id = rx_id; v.rxc = rxc;
        v.e_txs = e_txs; v.e_txid = e_txid; v.e_txc = e_txc; v.e_rxr = e_rxr;
        v.e_rxid = e_rxid; v.e_nrc = e_nrc;
        return v;
    endfunction

    // Reference model state (transaction level).
    bit         m_busy;
    int         m_g, m_ptr, m_grants, m_drops;
    packet      m_pkt;
    logic [7:0] m_orig;
    bit         m_out [N];
    logic [7:0] m_saved [N];

    initial begin
        vec_t         tv [7];
        packet        p1, rp, exp_p;
        int           ev_idx [$];
        int           ev_cyc [$];
        logic [N-1:0] drop, pend;
        int           g0, g2, exp_order [3];
        bit           got, rx_active, rx_done;

        // ---------------- reset state ----------------
        rst = 1'b0;
        init_pkts();
        idle_inputs();
        req_tx_submit   = 4'hF;
        noc_prt_open    = 1'b1;
        noc_tx_complete = 1'b1;
        noc_rx_recieve  = 1'b1;
        noc_rx_packet.id = 8'h03;
        @(negedge clk);
        chk("rst_tx_submit", noc_tx_submit, 0);
        chk("rst_tx_complete", req_tx_complete, 0);
        chk("rst_rx_recieve", req_rx_recieve, 0);
        chk("rst_noc_rx_complete", noc_rx_complete, 0);
        chk("rst_tx_packet", noc_tx_packet, 0);
        chk("rst_rx_packet", req_rx_packet, 0);
`ifdef NOC_ARB_STATS_EN
        chk("rst_stat_grants", stat_grants, 0);
        chk("rst_stat_drops", stat_drops, 0);
`endif

        // ---------------- table: single requester flow ----------------
        do_reset();
        p1.ptype = memory_read_request; p1.id = 8'd5; p1.addr = 32'h1000_0040; p1.data = 32'hCAFE_0001;
        req_tx_packet[1] = p1;
        rp.ptype = memory_read_reply; rp.id = 8'd0; rp.addr = 32'h1000_0040; rp.data = 32'hD00D_0001;
        tv[0] = mk(4'b0010, 1, 0, 0, 8'd0, 4'b0000, 0, 8'd0, 4'b0000, 4'b0000, 8'd0, 0);
        tv[1] = mk(4'b0010, 1, 1, 0, 8'd0, 4'b0000, 1, 8'd1, 4'b0010, 4'b0000, 8'd0, 0);
        tv[2] = mk(4'b0000, 0, 0, 1, 8'd1, 4'b0000, 0, 8'd0, 4'b0000, 4'b0010, 8'd5, 0);
        tv[3] = mk(4'b0000, 0, 0, 1, 8'd1, 4'b0010, 0, 8'd0, 4'b0000, 4'b0010, 8'd5, 1);
        tv[4] = mk(4'b0000, 0, 0, 1, 8'd1, 4'b0010, 0, 8'd0, 4'b0000, 4'b0000, 8'd0, 1);
        tv[5] = mk(4'b0000, 0, 0, 1, 8'd3, 4'b1000, 0, 8'd0, 4'b0000, 4'b0000, 8'd0, 1);
        tv[6] = mk(4'b0000, 0, 0, 0, 8'd0, 4'b0000, 0, 8'd0, 4'b0000, 4'b0000, 8'd0, 0);
        for (int r = 0; r < 7; r++) begin
            req_tx_submit    = tv[r].sub;
            noc_prt_open     = tv[r].open;
            noc_tx_complete  = tv[r].cmpl;
            noc_rx_recieve   = tv[r].rxv;
            noc_rx_packet    = rp;
            noc_rx_packet.id = tv[r].rx_id;
            req_rx_complete  = tv[r].rxc;
            @(negedge clk);
            chk($sformatf("tv%0d_tx_submit", r), noc_tx_submit, tv[r].e_txs);
            if (tv[r].e_txs) begin
                exp_p = p1;
                exp_p.id = tv[r].e_txid;
                chk($sformatf("tv%0d_tx_packet", r), noc_tx_packet, exp_p);
            end
            chk($sformatf("tv%0d_tx_complete", r), req_tx_complete, tv[r].e_txc);
            chk($sformatf("tv%0d_rx_recieve", r), req_rx_recieve, tv[r].e_rxr);
            exp_p = '0;
            if (tv[r].e_rxr != 0) begin
                exp_p = rp;
                exp_p.id = tv[r].e_rxid;
            end
            chk($sformatf("tv%0d_rx_packet", r), req_rx_packet, exp_p);
            chk($sformatf("tv%0d_noc_rx_complete", r), noc_rx_complete, tv[r].e_nrc);
            cycle();
        end
`ifdef NOC_ARB_STATS_EN
        chk("tv_stat_grants", stat_grants, 1);
        chk("tv_stat_drops", stat_drops, 2);
`endif
        init_pkts();

        // ---------------- round robin 0,1,3 from reset ----------------
        do_reset();
        req_tx_submit = 4'b1011; noc_prt_open = 1'b1; noc_tx_complete = 1'b1;
        drop = '0;
        for (int c = 0; c < 10; c++) begin
            req_tx_submit = req_tx_submit & ~drop;
            @(negedge clk);
            if (c == 0) chk("rr_latency_c0", noc_tx_submit, 0);
            if (c == 1) chk("rr_latency_c1", noc_tx_submit, 1);
            drop = req_tx_complete;
            if (req_tx_complete != 0) begin
                chk("rr_onehot", 32'($countones(req_tx_complete)), 1);
                chk("rr_tx_id", noc_tx_packet.id, 8'(idx_of(req_tx_complete)));
                ev_idx.push_back(idx_of(req_tx_complete));
                ev_cyc.push_back(c);
            end
            cycle();
        end
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 3;
        chk("rr_grant_count", 32'(ev_idx.size()), 3);
        for (int k = 0; k < 3 && k < ev_idx.size(); k++) begin
            chk($sformatf("rr_order%0d", k), 32'(ev_idx[k]), 32'(exp_order[k]));
            chk($sformatf("rr_cycle%0d", k), 32'(ev_cyc[k]), 32'(1 + 2 * k));
        end

        // ---------------- re-submit before reply ----------------
        do_reset();
        req_tx_submit = 4'b0100; noc_prt_open = 1'b1; noc_tx_complete = 1'b1;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (req_tx_complete != 0) begin
                got = 1;
                chk("rs_first_grant", req_tx_complete, 4'b0100);
            end
            cycle();
        end
        chk("rs_first_grant_seen", got, 1);
        req_tx_submit = 4'b0101;
        g0 = 0; g2 = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_tx_complete[0]) g0++;
            if (req_tx_complete[2]) g2++;
            cycle();
            if (g0 != 0) req_tx_submit[0] = 1'b0;
        end
        chk("rs_grant0_count", 32'(g0), 1);
        chk("rs_grant2_blocked", 32'(g2), 0);
        noc_rx_recieve = 1'b1; noc_rx_packet = rp; noc_rx_packet.id = 8'h02; req_rx_complete = 4'b0100;
        @(negedge clk);
        chk("rs_rx_recieve", req_rx_recieve, 4'b0100);
        chk("rs_rx_restored_id", req_rx_packet.id, 8'h12);
        chk("rs_noc_rx_complete", noc_rx_complete, 1);
        cycle();
        noc_rx_recieve = 1'b0; req_rx_complete = '0;
        @(negedge clk);
        chk("rs_regrant_wait", noc_tx_submit, 0);
        cycle();
        @(negedge clk);
        chk("rs_regrant_submit", noc_tx_submit, 1);
        chk("rs_regrant_complete", req_tx_complete, 4'b0100);
        chk("rs_regrant_id", noc_tx_packet.id, 8'd2);
        cycle();

        // ---------------- port closed during grant ----------------
        do_reset();
        req_tx_submit = 4'b0001; noc_prt_open = 1'b0; noc_tx_complete = 1'b1;
        @(negedge clk);
        chk("pc_idle", noc_tx_submit, 0);
        cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("pc_held%0d", c), noc_tx_submit, 1);
            chk($sformatf("pc_nocomplete%0d", c), req_tx_complete, 0);
            cycle();
        end
        noc_prt_open = 1'b1;
        @(negedge clk);
        chk("pc_open_complete", req_tx_complete, 4'b0001);
        cycle();
        req_tx_submit = '0;
        @(negedge clk);
        chk("pc_after", noc_tx_submit, 0);
        cycle();

        // ---------------- reset mid-grant ----------------
        do_reset();
        req_tx_submit = 4'b0001; noc_prt_open = 1'b1; noc_tx_complete = 1'b1;
        cycle();
        @(negedge clk);
        chk("mr_pre_grant0", req_tx_complete, 4'b0001);
        cycle();
        req_tx_submit = 4'b0100; noc_prt_open = 1'b0;
        cycle();
        @(negedge clk);
        chk("mr_in_grant", noc_tx_submit, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_submit_drop", noc_tx_submit, 0);
        chk("mr_packet_clear", noc_tx_packet, 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        req_tx_submit = 4'b0101; noc_prt_open = 1'b1; noc_tx_complete = 1'b1;
        @(negedge clk);
        chk("mr_restart_idle", noc_tx_submit, 0);
        cycle();
        @(negedge clk);
        chk("mr_restart_grant0", req_tx_complete, 4'b0001);
        chk("mr_restart_id", noc_tx_packet.id, 8'd0);
        cycle();

        // ---------------- randomized run against the model ----------------
        do_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_pkt = '0; m_orig = '0; m_grants = 0; m_drops = 0;
        for (int i = 0; i < N; i++) begin m_out[i] = 0; m_saved[i] = '0; end
        drop = '0; pend = '0; rx_active = 0; rx_done = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] e_txc, e_rxr;
            packet        e_rxp;
            bit           fire, hit, e_nrc, found;
            int           k;

            for (int i = 0; i < N; i++) begin
                if (drop[i]) req_tx_submit[i] = 1'b0;
                else if (!req_tx_submit[i] && $urandom_range(0, 3) == 0) begin
                    req_tx_submit[i] = 1'b1;
                    req_tx_packet[i] = rand_pkt();
                end
                if ($urandom_range(0, 7) == 0) req_tx_packet[i] = rand_pkt();
            end
            noc_prt_open    = ($urandom_range(0, 3) != 0);
            noc_tx_complete = ($urandom_range(0, 2) != 0);
            if (rx_active && rx_done) rx_active = 0;
            if (!rx_active && $urandom_range(0, 2) == 0) begin
                rx_active = 1;
                noc_rx_packet = rand_pkt();
                if (pend != 0 && $urandom_range(0, 3) != 0) begin
                    int j;
                    j = $urandom_range(0, N - 1);
                    while (!pend[j]) j = (j + 1) % N;
                    noc_rx_packet.id[1:0] = 2'(j);
                end
            end
            noc_rx_recieve  = rx_active;
            req_rx_complete = 4'($urandom);

            @(negedge clk);
            fire  = m_busy && noc_prt_open && noc_tx_complete;
            e_txc = fire ? (4'b0001 << m_g) : 4'b0000;
            k     = int'(noc_rx_packet.id[1:0]);
            hit   = noc_rx_recieve && m_out[k];
            e_rxr = hit ? (4'b0001 << k) : 4'b0000;
            e_rxp = '0;
            if (hit) begin e_rxp = noc_rx_packet; e_rxp.id = m_saved[k]; end
            e_nrc = noc_rx_recieve && (hit ? req_rx_complete[k] : 1'b1);

            chk("rnd_tx_submit", noc_tx_submit, m_busy);
            if (m_busy) chk("rnd_tx_packet", noc_tx_packet, m_pkt);
            chk("rnd_tx_complete", req_tx_complete, e_txc);
            chk("rnd_rx_recieve", req_rx_recieve, e_rxr);
            chk("rnd_rx_packet", req_rx_packet, e_rxp);
            chk("rnd_noc_rx_complete", noc_rx_complete, e_nrc);

            if (!m_busy) begin
                found = 0;
                for (int j = 0; j < N; j++) begin
                    int cand;
                    cand = (m_ptr + j) % N;
                    if (!found && req_tx_submit[cand] && !m_out[cand]) begin
                        found  = 1;
                        m_busy = 1;
                        m_g    = cand;
                        m_orig = req_tx_packet[cand].id;
                        m_pkt  = req_tx_packet[cand];
                        m_pkt.id = 8'(cand);
                    end
                end
            end else if (fire) begin
                m_out[m_g]   = 1;
                m_saved[m_g] = m_orig;
                m_ptr        = (m_g + 1) % N;
                m_busy       = 0;
                m_grants++;
            end
            if (hit && req_rx_complete[k]) m_out[k] = 0;
            if (noc_rx_recieve && !hit) m_drops++;

            drop    = req_tx_complete;
            rx_done = noc_rx_complete;
            if (req_tx_complete != 0) pend[idx_of(req_tx_complete)] = 1'b1;
            if (hit && noc_rx_complete) pend[k] = 1'b0;
            cycle();
        end
`ifdef NOC_ARB_STATS_EN
        chk("rnd_stat_grants", stat_grants, 32'(m_grants));
        chk("rnd_stat_drops", stat_drops, 32'(m_drops));
`endif
        chk("rnd_grants_seen", 32'(m_grants > 50), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
